// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
// FSM encoding and the BCD range constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int          BCD_DIGITS   = 8;
    localparam logic [31:0] BCD_MAX      = 32'd99_999_999;
    localparam logic [31:0] BCD_ERR_WORD = 32'hEEEE_EEEE;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_disp.sv
// Iterative binary to 8-digit packed BCD converter, one bit per clock.
// The display word only changes when a conversion completes.
module bin2bcd_disp
    import bcd_pkg::*;
#(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      data,
    output logic             disp_en
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_e       state;
    bcd_state_e       state_nxt;
    logic [31:0]      scratch;
    logic [31:0]      scratch_adj;
    logic [BIN_W-1:0] binreg;
    logic [CNT_W-1:0] cnt;
    logic             ovf_flag;
    logic             accept;

    assign accept = (state == IDLE) && start;

    // The done cycle still counts as busy so the result is never
    // seen with busy already low.
    assign busy = (state != IDLE) || done;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[4*g +: 4]),
            .q (scratch_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch  <= '0;
            binreg   <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else if (accept) begin
            scratch  <= '0;
            binreg   <= bin;
            cnt      <= CNT_W'(BIN_W);
            ovf_flag <= (32'(bin) > BCD_MAX);
        end else if (state == SHIFT) begin
            // Carry out of digit 7 is dropped; legal inputs never make one.
            scratch <= {scratch_adj[30:0], binreg[BIN_W-1]};
            binreg  <= binreg << 1;
            cnt     <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            ovf     <= 1'b0;
            disp_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                data    <= ovf_flag ? BCD_ERR_WORD : scratch;
                ovf     <= ovf_flag;
                disp_en <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Directed bench for bin2bcd_disp: latency, boundaries,
// held start, reset abort and back-to-back conversions.
module tb_bin2bcd_disp;

    logic        clk;
    logic        reset;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [31:0] data;
    logic        disp_en;

    int tests;
    int fails;

    bin2bcd_disp #(.BIN_W(27)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .data    (data),
        .disp_en (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start with v, then returns the edge count to done
    // (-1 if done never appears within 40 cycles).
    task automatic run_conv(input logic [26:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 27'h5A5_A5A5;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat;
        #1;
        tests++;
        if ({busy, done, ovf, disp_en} !== 4'b0000 || data !== 32'h0) begin
            fails++;
            $display("FAIL reset_init: got b%b d%b o%b e%b data %h want 0",
                     busy, done, ovf, disp_en, data);
        end
        @(negedge clk);
        reset = 1'b0;
        run_conv(27'd42, lat);
        tests++;
        if (lat !== 28 || data !== 32'h0000_0042) begin
            fails++;
            $display("FAIL reset_pre: lat %0d data %h want 28 00000042",
                     lat, data);
        end
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, ovf, disp_en} !== 4'b0000 || data !== 32'h0) begin
            fails++;
            $display("FAIL reset_async: got b%b d%b o%b e%b data %h want 0",
                     busy, done, ovf, disp_en, data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        run_conv(27'd12_345_678, lat);
        tests++;
        if (lat !== 28) begin
            fails++;
            $display("FAIL basic_lat: got %0d want 28", lat);
        end
        tests++;
        if (data !== 32'h1234_5678 || ovf !== 1'b0 || disp_en !== 1'b1) begin
            fails++;
            $display("FAIL basic_out: data %h ovf %b en %b want 12345678 0 1",
                     data, ovf, disp_en);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy_done: got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_after: busy %b done %b data %h want 0 0 12345678",
                     busy, done, data);
        end
    endtask

    task automatic test_boundaries;
        logic [26:0] vin  [3] = '{27'd0, 27'd99_999_999, 27'd100_000_000};
        logic [31:0] vexp [3] = '{32'h0000_0000, 32'h9999_9999, 32'hEEEE_EEEE};
        logic        vovf [3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        for (int k = 0; k < 3; k++) begin
            run_conv(vin[k], lat);
            tests++;
            if (lat !== 28 || data !== vexp[k] || ovf !== vovf[k]) begin
                fails++;
                $display("FAIL bound_%0d: lat %0d data %h ovf %b want 28 %h %b",
                         k, lat, data, ovf, vexp[k], vovf[k]);
            end
        end
    endtask

    task automatic test_held_start;
        int ndone;
        int badpos;
        int baddata;
        int drained;
        ndone   = 0;
        badpos  = 0;
        baddata = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd87_654_321;
        @(posedge clk);
        for (int k = 1; k <= 87; k++) begin
            @(negedge clk);
            bin = (k % 29 == 0) ? 27'd87_654_321 : 27'(k * 1234567);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (k % 29 != 28) badpos++;
                if (data !== 32'h8765_4321) baddata++;
            end
        end
        start = 1'b0;
        tests++;
        if (ndone !== 3 || badpos !== 0) begin
            fails++;
            $display("FAIL held_count: dones %0d misplaced %0d want 3 0",
                     ndone, badpos);
        end
        tests++;
        if (baddata !== 0) begin
            fails++;
            $display("FAIL held_data: bad %0d want 0 (data %h)", baddata, data);
        end
        drained = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                drained = 1;
                break;
            end
        end
        tests++;
        if (drained !== 1) begin
            fails++;
            $display("FAIL held_drain: busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int spurious;
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd89_999_999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, ovf, disp_en} !== 4'b0000 || data !== 32'h0) begin
            fails++;
            $display("FAIL abort_out: got b%b d%b o%b e%b data %h want 0",
                     busy, done, ovf, disp_en, data);
        end
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) spurious++;
        end
        tests++;
        if (spurious !== 0 || data !== 32'h0) begin
            fails++;
            $display("FAIL abort_quiet: activity %0d data %h want 0 0",
                     spurious, data);
        end
        run_conv(27'd89_999_999, lat);
        tests++;
        if (lat !== 28 || data !== 32'h8999_9999 || disp_en !== 1'b1) begin
            fails++;
            $display("FAIL abort_next: lat %0d data %h en %b want 28 89999999 1",
                     lat, data, disp_en);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int badhold;
        run_conv(27'd11_111_111, lat);
        tests++;
        if (lat !== 28 || data !== 32'h1111_1111) begin
            fails++;
            $display("FAIL b2b_first: lat %0d data %h want 28 11111111",
                     lat, data);
        end
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd22_222_222;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy %b want 1", busy);
        end
        lat     = -1;
        badhold = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (data !== 32'h1111_1111) badhold++;
        end
        tests++;
        if (lat !== 28 || badhold !== 0) begin
            fails++;
            $display("FAIL b2b_second: lat %0d holdbad %0d want 28 0",
                     lat, badhold);
        end
        tests++;
        if (data !== 32'h2222_2222) begin
            fails++;
            $display("FAIL b2b_data: got %h want 22222222", data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_held_start();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
